// File: rtl/tw_pkg.sv
// rtl/tw_pkg.sv - shared types and constants for the horizontal twiddle link
package tw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_HI,
    ST_GAP_W,
    ST_SEND_LO,
    ST_FIN
  } tw_tx_state_t;

  localparam logic [1:0] ROM6W_NONE = 2'd0;
  localparam logic [1:0] ROM6W_HI   = 2'd1;
  localparam logic [1:0] ROM6W_LO   = 2'd2;

  // horizontal_DW is always P_WIDTH / HDW_DIV: one twiddle word spans two bus beats
  localparam int HDW_DIV = 2;

endpackage

// File: rtl/tw_horizontal_tx_if.sv
// rtl/tw_horizontal_tx_if.sv - upstream entry handshake plus horizontal bus
interface tw_horizontal_tx_if #(
  parameter int P_WIDTH       = 128,
  parameter int horizontal_DW = 64
);
  logic                     in_valid;
  logic [P_WIDTH-1:0]       in_data;
  logic                     in_ready;
  logic [1:0]               ROM6_w;
  logic [horizontal_DW-1:0] horizontal_data_out;

  modport master (
    input  in_valid, in_data,
    output in_ready, ROM6_w, horizontal_data_out
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, ROM6_w, horizontal_data_out
  );
endinterface

// File: rtl/tw_entry_buf.sv
// rtl/tw_entry_buf.sv - entry register file with half-select read by write code
module tw_entry_buf
  import tw_pkg::*;
#(
  parameter int P_WIDTH   = 128,
  parameter int ENTRY_NUM = 4,
  localparam int AW       = $clog2(ENTRY_NUM),
  localparam int HALF     = P_WIDTH / HDW_DIV
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [P_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  input  logic [1:0]         rd_code,
  output logic [HALF-1:0]    rd_data
);
  logic [P_WIDTH-1:0] mem [ENTRY_NUM];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRY_NUM; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_code)
      ROM6W_HI: rd_data = mem[rd_addr][P_WIDTH-1:HALF];
      ROM6W_LO: rd_data = mem[rd_addr][HALF-1:0];
      default:  rd_data = '0;
    endcase
  end
endmodule

// File: rtl/tw_horizontal_tx.sv
// rtl/tw_horizontal_tx.sv - collects ENTRY_NUM twiddle words and sends HI then LO halves
module tw_horizontal_tx
  import tw_pkg::*;
#(
  parameter int P_WIDTH       = 128,
  parameter int horizontal_DW = 64,
  parameter int ENTRY_NUM     = 4,
  parameter int GAP           = 0
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  tw_horizontal_tx_if.master  bus,
  output logic                busy,
  output logic                done
);
  localparam int AW = $clog2(ENTRY_NUM);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [AW-1:0] LAST = AW'(ENTRY_NUM - 1);

  tw_tx_state_t             state, state_d;
  logic [AW-1:0]            idx, idx_d, load_cnt, load_cnt_d;
  logic [GW-1:0]            gap_cnt, gap_cnt_d;
  logic                     wr_en;
  logic [1:0]               code_d, code_q;
  logic [horizontal_DW-1:0] rd_data, data_q;
  logic                     ready_q, busy_q, done_q;

  // Outputs are registered from the next state, so the buffer is read at idx_d
  tw_entry_buf #(.P_WIDTH(P_WIDTH), .ENTRY_NUM(ENTRY_NUM)) u_buf (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (load_cnt),
    .wr_data (bus.in_data),
    .rd_addr (idx_d),
    .rd_code (code_d),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    load_cnt_d = load_cnt;
    gap_cnt_d  = gap_cnt;
    wr_en      = 1'b0;
    if (abort) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      load_cnt_d = '0;
      gap_cnt_d  = '0;
    end else begin
      case (state)
        ST_IDLE: if (start) state_d = ST_LOAD;
        ST_LOAD: begin
          if (bus.in_valid && ready_q) begin
            wr_en      = 1'b1;
            load_cnt_d = load_cnt + 1'b1;
            if (load_cnt == LAST) begin
              state_d = ST_SEND_HI;
              idx_d   = '0;
            end
          end
        end
        ST_SEND_HI: begin
          idx_d = idx + 1'b1;
          if (idx == LAST) state_d = (GAP > 0) ? ST_GAP_W : ST_SEND_LO;
        end
        ST_GAP_W: begin
          gap_cnt_d = gap_cnt + 1'b1;
          if (gap_cnt == GW'(GAP - 1)) begin
            state_d   = ST_SEND_LO;
            gap_cnt_d = '0;
          end
        end
        ST_SEND_LO: begin
          idx_d = idx + 1'b1;
          if (idx == LAST) state_d = ST_FIN;
        end
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    case (state_d)
      ST_SEND_HI: code_d = ROM6W_HI;
      ST_SEND_LO: code_d = ROM6W_LO;
      default:    code_d = ROM6W_NONE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      load_cnt <= '0;
      gap_cnt  <= '0;
      code_q   <= ROM6W_NONE;
      data_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      load_cnt <= load_cnt_d;
      gap_cnt  <= gap_cnt_d;
      code_q   <= code_d;
      data_q   <= rd_data;
      ready_q  <= (state_d == ST_LOAD);
      busy_q   <= (state_d inside {ST_LOAD, ST_SEND_HI, ST_GAP_W, ST_SEND_LO});
      done_q   <= (state_d == ST_FIN);
    end
  end

  assign bus.in_ready            = ready_q;
  assign bus.ROM6_w              = code_q;
  assign bus.horizontal_data_out = data_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
endmodule

// File: tb/tb_tw_horizontal_tx.sv
// tb/tb_tw_horizontal_tx.sv - table-driven bench for tw_horizontal_tx (GAP 0 and GAP 2 side by side)
module tb_tw_horizontal_tx;
  import tw_pkg::*;

  localparam int PW  = 128;
  localparam int HDW = 64;
  localparam int EN  = 4;

  logic CLK   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy_n, done_n, busy_g, done_g;

  tw_horizontal_tx_if #(.P_WIDTH(PW), .horizontal_DW(HDW)) n_if ();
  tw_horizontal_tx_if #(.P_WIDTH(PW), .horizontal_DW(HDW)) g_if ();

  assign g_if.in_valid = n_if.in_valid;
  assign g_if.in_data  = n_if.in_data;

  tw_horizontal_tx #(.P_WIDTH(PW), .horizontal_DW(HDW), .ENTRY_NUM(EN), .GAP(0)) dut_n (
    .CLK(CLK), .rst_n(rst_n), .start(start), .abort(abort),
    .bus(n_if.master), .busy(busy_n), .done(done_n)
  );

  tw_horizontal_tx #(.P_WIDTH(PW), .horizontal_DW(HDW), .ENTRY_NUM(EN), .GAP(2)) dut_g (
    .CLK(CLK), .rst_n(rst_n), .start(start), .abort(abort),
    .bus(g_if.master), .busy(busy_g), .done(done_g)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         start;
    logic         valid;
    logic [127:0] data;
    logic [1:0]   code;
    logic [63:0]  hd;
    logic         rdy;
    logic         busy;
    logic         done;
    logic [1:0]   gcode;
    logic [63:0]  ghd;
    logic         gdone;
  } vec_t;

  vec_t vq[$];
  int errors = 0;
  int checks = 0;
  logic [127:0] da [4];
  logic [127:0] db [4];
  logic [127:0] dc [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Row k: outputs expected in cycle k, inputs driven in cycle k
  task automatic build(input logic [127:0] d [4], input bit bp, input bit hi_start);
    vec_t r;
    r = '{default: '0};
    r.start = 1'b1;
    vq.push_back(r);
    for (int k = 0; k < 4; k++) begin
      r = '{default: '0};
      r.valid = 1'b1; r.data = d[k]; r.rdy = 1'b1; r.busy = 1'b1;
      vq.push_back(r);
      if (bp && k < 3) begin
        r.valid = 1'b0; r.data = {4{32'hdeadbeef}};
        vq.push_back(r);
      end
    end
    for (int c = 0; c < 12; c++) begin
      r = '{default: '0};
      r.start = hi_start && (c == 1);
      if (c < 4) begin
        r.code = ROM6W_HI; r.hd = d[c][127:64];
        r.gcode = ROM6W_HI; r.ghd = d[c][127:64];
      end else if (c < 8) begin
        r.code = ROM6W_LO; r.hd = d[c-4][63:0];
      end
      if (c >= 6 && c < 10) begin
        r.gcode = ROM6W_LO; r.ghd = d[c-6][63:0];
      end
      r.busy  = (c < 8);
      r.done  = (c == 8);
      r.gdone = (c == 10);
      vq.push_back(r);
    end
  endtask

  task automatic run(input string tag);
    foreach (vq[i]) begin
      @(negedge CLK);
      chk($sformatf("%s r%0d code", tag, i), n_if.ROM6_w, vq[i].code);
      chk($sformatf("%s r%0d data", tag, i), n_if.horizontal_data_out, vq[i].hd);
      chk($sformatf("%s r%0d in_ready", tag, i), n_if.in_ready, vq[i].rdy);
      chk($sformatf("%s r%0d busy", tag, i), busy_n, vq[i].busy);
      chk($sformatf("%s r%0d done", tag, i), done_n, vq[i].done);
      chk($sformatf("%s r%0d gap code", tag, i), g_if.ROM6_w, vq[i].gcode);
      chk($sformatf("%s r%0d gap data", tag, i), g_if.horizontal_data_out, vq[i].ghd);
      chk($sformatf("%s r%0d gap done", tag, i), done_g, vq[i].gdone);
      start         = vq[i].start;
      n_if.in_valid = vq[i].valid;
      n_if.in_data  = vq[i].data;
    end
    vq.delete();
  endtask

  task automatic load(input logic [127:0] d [4]);
    @(negedge CLK); start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      start = 1'b0; n_if.in_valid = 1'b1; n_if.in_data = d[k];
    end
    @(negedge CLK); n_if.in_valid = 1'b0;
  endtask

  initial begin
    da = '{128'h0000000000000001_0000000000000001, 128'h0200000000000000_585bda2e086ebc26,
           128'hfffffffefffc0001_00000007fff7fff8, 128'hfffff7ff00000801_7202dad8187e103f};
    db = '{128'h1111111111111111_aaaaaaaaaaaaaaaa, 128'h2222222222222222_bbbbbbbbbbbbbbbb,
           128'h3333333333333333_cccccccccccccccc, 128'h4444444444444444_dddddddddddddddd};
    dc = '{128'h0123456789abcdef_fedcba9876543210, 128'h0f0f0f0f0f0f0f0f_f0f0f0f0f0f0f0f0,
           128'h8000000000000000_0000000000000001, 128'h7fffffffffffffff_ffffffffffffffff};
    n_if.in_valid = 1'b0;
    n_if.in_data  = '0;

    repeat (2) @(negedge CLK);
    chk("reset code", n_if.ROM6_w, ROM6W_NONE);
    chk("reset data", n_if.horizontal_data_out, 64'd0);
    chk("reset in_ready", n_if.in_ready, 1'b0);
    chk("reset busy", busy_n, 1'b0);
    chk("reset done", done_n, 1'b0);
    rst_n = 1'b1;

    build(da, 1'b0, 1'b0); run("nominal");
    build(da, 1'b1, 1'b0); run("backpressure");

    @(negedge CLK); start = 1'b1; abort = 1'b1;
    @(negedge CLK); start = 1'b0; abort = 1'b0;
    chk("start+abort in_ready", n_if.in_ready, 1'b0);
    chk("start+abort busy", busy_n, 1'b0);

    load(da);
    chk("abort hi0 code", n_if.ROM6_w, ROM6W_HI);
    @(negedge CLK);
    chk("abort hi1 data", n_if.horizontal_data_out, da[1][127:64]);
    abort = 1'b1;
    @(negedge CLK); abort = 1'b0;
    chk("abort code", n_if.ROM6_w, ROM6W_NONE);
    chk("abort data", n_if.horizontal_data_out, 64'd0);
    chk("abort busy", busy_n, 1'b0);
    chk("abort gap code", g_if.ROM6_w, ROM6W_NONE);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("abort no done %0d", i), {done_n, done_g}, 2'b00);
      @(negedge CLK);
    end
    build(db, 1'b0, 1'b0); run("after_abort");

    load(dc);
    repeat (5) @(negedge CLK);
    chk("pre-reset lo code", n_if.ROM6_w, ROM6W_LO);
    chk("pre-reset lo data", n_if.horizontal_data_out, dc[1][63:0]);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst code", n_if.ROM6_w, ROM6W_NONE);
    chk("async rst data", n_if.horizontal_data_out, 64'd0);
    chk("async rst busy", busy_n, 1'b0);
    chk("async rst gap code", g_if.ROM6_w, ROM6W_NONE);
    for (int i = 0; i < 4; i++) chk($sformatf("rst buf[%0d]", i), dut_n.u_buf.mem[i], 128'd0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("rst start busy %0d", i), busy_n, 1'b0);
      chk($sformatf("rst start in_ready %0d", i), n_if.in_ready, 1'b0);
    end
    rst_n = 1'b1; start = 1'b0;
    @(negedge CLK);
    chk("post-rst busy", busy_n, 1'b0);

    build(db, 1'b0, 1'b1); run("start_in_hi");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
